fetch_stall_scheduler: RTL and testbench
========================================

// Module: fetch_stall_scheduler
// PURPOSE
//   Sequences the stall and flush controls of the fetch-side stall queue.
//   The stall queue only tolerates single-cycle stalls. This block turns a multi-cycle
//   hazard request from decode into a train of 1-cycle stall pulses, each followed by
//   a drain gap. Branch redirects become a 1-cycle flush that aborts any hazard in progress.
//   Sits between decode/execute hazard logic and the stall queue's stall/flush inputs.
// PARAMETERS
//   MAX_STALLS   3   max stall pulses per hazard request; hazard_len is clamped to this
//   GAP_CYCLES   2   minimum non-stall cycles after each pulse (>=1)
//   PERF_W       16  width of the perf counters (STALL_PERF_EN only)
// PORTS
//   clk           in   1       single clock, rising edge
//   reset         in   1       asynchronous, active-high
//   hazard_valid  in   1       decode requests a stall train
//   hazard_len    in   2       requested pulses; 0 = no-op accept
//   hazard_ready  out  1       comb: state==IDLE && !redirect_valid
//   redirect_valid in  1       branch mispredict / redirect this cycle
//   queue_busy    in   1       stall queue's use_q feedback
//   stall         out  1       registered stall pulse to the queue
//   flush         out  1       registered flush pulse to the queue
//   sched_busy    out  1       state != IDLE
//   perf_stalls   out  PERF_W  stall pulses issued (saturating)
//   perf_flushes  out  PERF_W  flushes issued (saturating)
// BEHAVIOUR
//   - Reset: state=IDLE, stall=0, flush=0, pulse/gap counters=0, perf counters=0.
//     Asserting reset mid-train abandons the train immediately.
//   - Handshake: a request is accepted when hazard_valid && hazard_ready.
//     len = min(hazard_len, MAX_STALLS). If len==0, the request is accepted and the block
//     stays IDLE. Otherwise it goes to STALL, and stall=1 in the cycle after acceptance
//     (latency 1).
//   - States:
//     IDLE  -> STALL on an accepted request with len>0.
//     STALL -> stall=1 for exactly one cycle, remaining-=1, then go to DRAIN.
//     DRAIN -> stall=0. Gap counter loads GAP_CYCLES and counts down.
//       Exit only when gap==0 && !queue_busy. A busy queue extends DRAIN indefinitely.
//       Exit to STALL if remaining>0, otherwise to IDLE.
//   - stall is never high on two consecutive cycles.
//   - Redirect: redirect_valid in any state -> flush=1 next cycle, for exactly one cycle.
//     State goes to IDLE, remaining and gap are cleared, and stall=0 in that cycle.
//     Redirect has priority over a simultaneous hazard_valid; hazard_ready=0, so that
//     request is not accepted.
//     Back-to-back redirects produce back-to-back flush pulses.
//   - stall and flush are never both 1 in the same cycle.
//   - Counter widths: remaining is 2 bits; gap is $clog2(GAP_CYCLES+1) bits.
// CONFIGURATION
//   STALL_PERF_EN defined: perf_stalls += 1 per cycle with stall=1; perf_flushes += 1
//     per cycle with flush=1. Both saturate at all-ones and are cleared only by reset.
//   STALL_PERF_EN undefined: counters are not built; perf_stalls/perf_flushes are tied to 0.
// STRUCTURE
//   Package fetch_sched_pkg: state enum {IDLE, STALL, DRAIN} (2-bit), MAX_STALLS_W,
//     clamp function for hazard_len.
//   Sub-module sat_counter #(PERF_W): increment-enable with saturation.
//     Instantiated twice, only under STALL_PERF_EN.
// TESTING
//   1. Reset released, idle 5 cycles -> stall=0, flush=0, hazard_ready=1,
//      perf counters=0.
//   2. hazard_len=2 at cycle 10, GAP_CYCLES=2, queue_busy=0 -> stall high at cycles
//      11 and 14 only; sched_busy low from cycle 17.
//   3. hazard_len=3 with queue_busy held 1 through cycle 20 -> second pulse no earlier
//      than cycle 21; 3 pulses total.
//   4. redirect_valid at the cycle of the first pulse of a len=3 train -> flush=1 the
//      next cycle, no further stall pulses, IDLE.
//   5. hazard_valid and redirect_valid in the same cycle -> request not accepted,
//      flush=1 next cycle, stall stays 0.
//   6. STALL_PERF_EN with PERF_W=2: 5 stall pulses -> perf_stalls=3 (saturated).
//      Reset mid-train -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fetch_sched_pkg.sv
// rtl/fetch_sched_pkg.sv - shared state encoding and length clamp for the fetch stall scheduler
package fetch_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  localparam int MAX_STALLS_W = 2;

  function automatic logic [MAX_STALLS_W-1:0] clamp_len(input logic [1:0] len,
                                                        input int max_stalls);
    if (int'(len) > max_stalls) return MAX_STALLS_W'(max_stalls);
    return len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - increment-enable counter that holds at all-ones
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_stall_scheduler.sv
// rtl/fetch_stall_scheduler.sv - splits hazard requests into 1-cycle stall pulses with drain gaps
// STALL_PERF_EN builds the saturating stall/flush perf counters; otherwise they read 0.
module fetch_stall_scheduler
  import fetch_sched_pkg::*;
#(
  parameter int MAX_STALLS = 3,
  parameter int GAP_CYCLES = 2,
  parameter int PERF_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hazard_valid,
  input  logic [1:0]        hazard_len,
  output logic              hazard_ready,
  input  logic              redirect_valid,
  input  logic              queue_busy,
  output logic              stall,
  output logic              flush,
  output logic              sched_busy,
  output logic [PERF_W-1:0] perf_stalls,
  output logic [PERF_W-1:0] perf_flushes
);

  localparam int               GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  sched_state_e            state_q, state_d;
  logic [MAX_STALLS_W-1:0] remaining_q, remaining_d;
  logic [GAP_W-1:0]        gap_q, gap_d, gap_dec;
  logic [MAX_STALLS_W-1:0] len;
  logic                    accept;
  logic                    stall_q, flush_q;

  assign hazard_ready = (state_q == IDLE) && !redirect_valid;
  assign accept       = hazard_valid && hazard_ready;
  assign len          = clamp_len(hazard_len, MAX_STALLS);
  assign gap_dec      = (gap_q == '0) ? '0 : gap_q - GAP_W'(1);

  // gap counts drain cycles still owed including the current one, so the
  // pulse-to-pulse spacing is exactly GAP_CYCLES idle cycles when not busy
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    gap_d       = gap_q;
    if (redirect_valid) begin
      state_d     = IDLE;
      remaining_d = '0;
      gap_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && (len != '0)) begin
            state_d     = STALL;
            remaining_d = len;
          end
        end
        STALL: begin
          remaining_d = remaining_q - MAX_STALLS_W'(1);
          gap_d       = GAP_LOAD;
          state_d     = DRAIN;
        end
        DRAIN: begin
          gap_d = gap_dec;
          if ((gap_dec == '0) && !queue_busy)
            state_d = (remaining_q != '0) ? STALL : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      gap_q       <= '0;
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      stall_q     <= (state_d == STALL);
      flush_q     <= redirect_valid;
    end
  end

  assign stall      = stall_q;
  assign flush      = flush_q;
  assign sched_busy = (state_q != IDLE);

`ifdef STALL_PERF_EN
  sat_counter #(.WIDTH(PERF_W)) u_perf_stalls (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (stall_q),
    .count_o (perf_stalls)
  );

  sat_counter #(.WIDTH(PERF_W)) u_perf_flushes (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (flush_q),
    .count_o (perf_flushes)
  );
`else
  assign perf_stalls  = '0;
  assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_fetch_stall_scheduler.sv
// tb/tb_fetch_stall_scheduler.sv - directed self-checking bench for fetch_stall_scheduler
module tb_fetch_stall_scheduler;

`ifdef STALL_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hazard_valid = 1'b0;
  logic [1:0] hazard_len = 2'd0;
  logic       redirect_valid = 1'b0;
  logic       queue_busy = 1'b0;
  logic       hazard_ready, stall, flush, sched_busy;
  logic [1:0] perf_stalls, perf_flushes;

  int vectors = 0;
  int miscompares = 0;
  int pulses;

  always #5 clk = ~clk;

  fetch_stall_scheduler #(
    .MAX_STALLS (3),
    .GAP_CYCLES (2),
    .PERF_W     (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hazard_valid   (hazard_valid),
    .hazard_len     (hazard_len),
    .hazard_ready   (hazard_ready),
    .redirect_valid (redirect_valid),
    .queue_busy     (queue_busy),
    .stall          (stall),
    .flush          (flush),
    .sched_busy     (sched_busy),
    .perf_stalls    (perf_stalls),
    .perf_flushes   (perf_flushes)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pexp(input int n);
    if (!PERF_ON) return 2'd0;
    return (n >= 3) ? 2'd3 : 2'(n);
  endfunction

  initial begin
    // reset and idle
    tick();
    tick();
    reset = 1'b0;
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_flush", flush, 1'b0);
    chk1("rst_busy", sched_busy, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk1($sformatf("idle_stall_%0d", k), stall, 1'b0);
      chk1($sformatf("idle_flush_%0d", k), flush, 1'b0);
    end
    chk1("idle_ready", hazard_ready, 1'b1);
    chk2("idle_perf_stalls", perf_stalls, 2'd0);
    chk2("idle_perf_flushes", perf_flushes, 2'd0);

    // len=2, queue idle: pulses at +1 and +4, idle from +7
    hazard_valid = 1'b1;
    hazard_len   = 2'd2;
    #1 chk1("t2_ready", hazard_ready, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) hazard_valid = 1'b0;
      chk1($sformatf("t2_stall_%0d", k), stall, (k == 1) || (k == 4));
      chk1($sformatf("t2_busy_%0d", k), sched_busy, k < 7);
    end

    // len=3 with busy queue held until cycle +9
    hazard_valid = 1'b1;
    hazard_len   = 2'd3;
    queue_busy   = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 1) hazard_valid = 1'b0;
      if (k == 9) queue_busy = 1'b0;
      if (stall) pulses++;
      chk1($sformatf("t3_stall_%0d", k), stall, (k == 1) || (k == 10) || (k == 13));
    end
    chki("t3_pulses", pulses, 3);
    chk1("t3_busy_end", sched_busy, 1'b0);

    // redirect during the first pulse aborts the train
    hazard_valid = 1'b1;
    hazard_len   = 2'd3;
    tick();
    hazard_valid = 1'b0;
    chk1("t4_first_pulse", stall, 1'b1);
    redirect_valid = 1'b1;
    #1 chk1("t4_ready_redirect", hazard_ready, 1'b0);
    tick();
    redirect_valid = 1'b0;
    chk1("t4_flush", flush, 1'b1);
    chk1("t4_stall", stall, 1'b0);
    chk1("t4_busy", sched_busy, 1'b0);
    for (int k = 3; k <= 6; k++) begin
      tick();
      chk1($sformatf("t4_stall_%0d", k), stall, 1'b0);
      chk1($sformatf("t4_flush_%0d", k), flush, 1'b0);
    end

    // redirect wins over simultaneous hazard
    hazard_valid   = 1'b1;
    hazard_len     = 2'd2;
    redirect_valid = 1'b1;
    #1 chk1("t5_ready", hazard_ready, 1'b0);
    tick();
    hazard_valid   = 1'b0;
    redirect_valid = 1'b0;
    chk1("t5_flush", flush, 1'b1);
    chk1("t5_stall", stall, 1'b0);
    chk1("t5_busy", sched_busy, 1'b0);
    tick();
    chk1("t5_flush_clear", flush, 1'b0);
    chk1("t5_stall_later", stall, 1'b0);

    // back-to-back redirects
    redirect_valid = 1'b1;
    tick();
    chk1("b2b_flush_1", flush, 1'b1);
    tick();
    redirect_valid = 1'b0;
    chk1("b2b_flush_2", flush, 1'b1);
    tick();
    chk1("b2b_flush_3", flush, 1'b0);

    // len=0 is accepted and leaves the block idle
    hazard_valid = 1'b1;
    hazard_len   = 2'd0;
    #1 chk1("len0_ready", hazard_ready, 1'b1);
    tick();
    hazard_valid = 1'b0;
    chk1("len0_busy", sched_busy, 1'b0);
    chk1("len0_stall", stall, 1'b0);

    // perf counters from a clean reset: 5 pulses saturate a 2-bit counter
    #2 reset = 1'b1;
    tick();
    reset = 1'b0;
    chk2("t6_perf_clear", perf_stalls, 2'd0);
    hazard_valid = 1'b1;
    hazard_len   = 2'd3;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) hazard_valid = 1'b0;
      if (k == 2) chk2("t6_perf_after1", perf_stalls, pexp(1));
    end
    chk2("t6_perf_after3", perf_stalls, pexp(3));
    hazard_valid = 1'b1;
    hazard_len   = 2'd2;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) hazard_valid = 1'b0;
      chk1($sformatf("t6_stall_%0d", k), stall, (k == 1) || (k == 4));
    end
    chk2("t6_perf_sat", perf_stalls, pexp(5));
    redirect_valid = 1'b1;
    tick();
    redirect_valid = 1'b0;
    tick();
    chk2("t6_perf_flushes", perf_flushes, pexp(1));

    // asynchronous reset mid-train
    hazard_valid = 1'b1;
    hazard_len   = 2'd3;
    tick();
    hazard_valid = 1'b0;
    chk1("t6_mid_pulse", stall, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("t6_async_stall", stall, 1'b0);
    chk1("t6_async_flush", flush, 1'b0);
    chk1("t6_async_busy", sched_busy, 1'b0);
    chk2("t6_async_perf_stalls", perf_stalls, 2'd0);
    chk2("t6_async_perf_flushes", perf_flushes, 2'd0);
    tick();
    reset = 1'b0;
    tick();
    chk1("t6_post_stall", stall, 1'b0);
    chk1("t6_post_busy", sched_busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
